// File: rtl/div_root_core.sv
// -----------------------------------------------------------------------------
// div_root_core
//
// Purpose:
//   Iterative arithmetic unit with two operations:
//     * unsigned restoring division of a DW-bit dividend by a VW-bit divisor,
//       one quotient bit per clock, MSB first (DW iterations);
//     * integer square root of a DW-bit radicand, digit-by-digit, two
//       radicand bits per clock (DW/2 iterations).
//   A divisor of zero bypasses iteration and returns an error result one
//   cycle after acceptance.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   high only while idle (request can be taken)
//   in_mode    in   1   0 = divide, 1 = square root
//   in_data_1  in   DW  dividend / radicand
//   in_data_2  in   VW  divisor (ignored for square root)
//   out_valid  out  1   result valid, held until out_ready is sampled high
//   out_ready  in   1   consumer accepts result
//   out_quo    out  DW  quotient / root (root zero-extended)
//   out_rem    out  DW  remainder / (radicand - root^2)
//   out_err    out  1   divide-by-zero flag
// -----------------------------------------------------------------------------
module div_root_core #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data_1,
  input  logic [VW-1:0] in_data_2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quo,
  output logic [DW-1:0] out_rem,
  output logic          out_err
);

  // Iteration counter width: enough to hold DW itself.
  localparam int CW = $clog2(DW + 1);
  // Partial-remainder width. Division needs VW+1 bits (VW <= DW), the root
  // needs DW/2+3 bits for the shifted remainder; DW+2 covers both.
  localparam int AW = DW + 2;

  localparam logic [CW-1:0] DIV_ITERS  = CW'(DW);
  localparam logic [CW-1:0] ROOT_ITERS = CW'(DW / 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;    // iterations still to perform
  logic [DW-1:0] r_sh;     // operand bits not yet consumed, MSB first
  logic [VW-1:0] r_d;      // captured divisor
  logic [DW-1:0] r_q;      // quotient / root bits built so far
  logic [AW-1:0] r_acc;    // partial remainder
  logic          r_dz;     // captured divide-by-zero condition

  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic          r_err;

  logic          w_last;

  // ---------------------------------------------------------------------------
  // Division step: bring down the next dividend bit and try to subtract the
  // divisor. The full-width shift keeps every accumulator bit in the compare.
  // ---------------------------------------------------------------------------
  logic [AW:0]   w_div_shift;
  logic [AW:0]   w_d_ext;
  logic          w_div_ge;
  logic [AW-1:0] w_div_acc;
  logic [DW-1:0] w_div_q;

  assign w_div_shift = {r_acc, r_sh[DW-1]};
  assign w_d_ext     = (AW + 1)'(r_d);
  assign w_div_ge    = (w_div_shift >= w_d_ext);
  assign w_div_acc   = AW'(w_div_ge ? (w_div_shift - w_d_ext) : w_div_shift);
  assign w_div_q     = {r_q[DW-2:0], w_div_ge};

  // ---------------------------------------------------------------------------
  // Root step: bring down the next two radicand bits and try to subtract
  // 4*root + 1. Success appends a 1 to the root, otherwise a 0.
  // ---------------------------------------------------------------------------
  logic [AW+1:0] w_rt_shift;
  logic [AW+1:0] w_rt_sub;
  logic          w_rt_ge;
  logic [AW-1:0] w_rt_acc;
  logic [DW-1:0] w_rt_q;

  assign w_rt_shift = {r_acc, r_sh[DW-1:DW-2]};
  assign w_rt_sub   = (AW + 2)'({r_q, 2'b01});
  assign w_rt_ge    = (w_rt_shift >= w_rt_sub);
  assign w_rt_acc   = AW'(w_rt_ge ? (w_rt_shift - w_rt_sub) : w_rt_shift);
  assign w_rt_q     = {r_q[DW-2:0], w_rt_ge};

  // The final iteration writes the result registers directly so that the
  // result is visible on the same edge the FSM enters DONE.
  assign w_last = (r_cnt == CNT_ONE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = in_mode ? ROOT : DIV;
        end
      end
      DIV: begin
        // A zero divisor spends exactly one cycle here and then reports.
        if (r_dz || w_last) begin
          w_state_next = DONE;
        end
      end
      ROOT: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
      r_d   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_dz  <= 1'b0;
      r_quo <= '0;
      r_rem <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh  <= in_data_1;
            r_d   <= in_data_2;
            r_q   <= '0;
            r_acc <= '0;
            r_dz  <= !in_mode && (in_data_2 == '0);
            if (in_mode) begin
              r_cnt <= ROOT_ITERS;
            end else if (in_data_2 == '0) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= DIV_ITERS;
            end
          end
        end
        DIV: begin
          if (r_dz) begin
            r_quo <= '1;
            r_rem <= r_sh;
            r_err <= 1'b1;
          end else if (r_cnt != '0) begin
            r_acc <= w_div_acc;
            r_q   <= w_div_q;
            r_sh  <= {r_sh[DW-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_ONE;
            if (w_last) begin
              r_quo <= w_div_q;
              r_rem <= DW'(w_div_acc);
              r_err <= 1'b0;
            end
          end
        end
        ROOT: begin
          if (r_cnt != '0) begin
            r_acc <= w_rt_acc;
            r_q   <= w_rt_q;
            r_sh  <= {r_sh[DW-3:0], 2'b00};
            r_cnt <= r_cnt - CNT_ONE;
            if (w_last) begin
              r_quo <= w_rt_q;
              r_rem <= DW'(w_rt_acc);
              r_err <= 1'b0;
            end
          end
        end
        default: begin
          // DONE: results held until consumed
        end
      endcase
    end
  end

  assign out_quo = r_quo;
  assign out_rem = r_rem;
  assign out_err = r_err;

endmodule

// File: tb/tb_div_root_core.sv
// -----------------------------------------------------------------------------
// tb_div_root_core
//
// Self-checking bench for div_root_core (DW=16, VW=8). A monitor keeps a
// queue of expected results computed with plain integer arithmetic at each
// acceptance and checks latency and values whenever out_valid is high.
// Directed cases pin literal results; randomized phases exercise
// back-to-back traffic, zero divisors and backpressure.
// -----------------------------------------------------------------------------
module tb_div_root_core;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] in_data_1;
  logic [VW-1:0] in_data_2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quo;
  logic [DW-1:0] out_rem;
  logic          out_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_acc = 0;
  int lat   = 0;

  typedef struct {
    int t;
    int lat;
    int q;
    int r;
    int e;
  } exp_t;

  exp_t exp_q[$];
  bit   seen_valid = 1'b0;

  div_root_core #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Expected result straight from the arithmetic definition.
  function automatic exp_t model(input int t, input logic m, input int a, input int b);
    exp_t x;
    x.t = t;
    if (m) begin
      int rt;
      rt = 0;
      while ((rt + 1) * (rt + 1) <= a) rt++;
      x.q   = rt;
      x.r   = a - rt * rt;
      x.e   = 0;
      x.lat = DW / 2;
    end else if (b == 0) begin
      x.q   = (1 << DW) - 1;
      x.r   = a;
      x.e   = 1;
      x.lat = 1;
    end else begin
      x.q   = a / b;
      x.r   = a % b;
      x.e   = 0;
      x.lat = DW;
    end
    return x;
  endfunction

  // Monitor / scoreboard: runs on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        seen_valid = 1'b0;
        chk("reset_out_valid", int'(out_valid), 0);
      end else begin
        if (exp_q.size() > 0 && !seen_valid && (cyc - exp_q[0].t) == exp_q[0].lat) begin
          chk("valid_on_time", int'(out_valid), 1);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: out_valid got 1 with nothing outstanding, required 0 (cycle %0d)", cyc);
          end else begin
            if (!seen_valid) chk("latency", cyc - exp_q[0].t, exp_q[0].lat);
            chk("quo", int'(out_quo), exp_q[0].q);
            chk("rem", int'(out_rem), exp_q[0].r);
            chk("err", int'(out_err), exp_q[0].e);
            chk("in_ready_in_done", int'(in_ready), 0);
            seen_valid = 1'b1;
            if (out_ready) begin
              void'(exp_q.pop_front());
              seen_valid = 1'b0;
            end
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(cyc + 1, in_mode, int'(in_data_1), int'(in_data_2)));
        end
      end
    end
  end

  // Present a request; called at posedge+1, returns at posedge+1 of acceptance.
  task automatic send(input logic m, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data_1 = a;
    in_data_2 = b;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0, required 1 within 100 cycles (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    t_acc     = cyc;
    in_valid  = 1'b0;
    // Scramble operands: the captured request must not depend on them.
    in_mode   = 1'($urandom);
    in_data_1 = DW'($urandom);
    in_data_2 = VW'($urandom);
  endtask

  // Wait for out_valid (checked on falling edges); returns cycles since acceptance.
  task automatic wait_out(output int l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout: out_valid got 0, required 1 within 100 cycles (cycle %0d)", cyc);
    end
    l = cyc - t_acc;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_quo", int'(out_quo), 0);
    chk("reset_rem", int'(out_rem), 0);
    chk("reset_err", int'(out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", int'(in_ready), 1);

    // 1000 / 7
    @(posedge clk); #1;
    send(1'b0, 16'd1000, 8'd7);
    wait_out(lat);
    chk("div_latency", lat, 16);
    chk("div_quo", int'(out_quo), 142);
    chk("div_rem", int'(out_rem), 6);
    chk("div_err", int'(out_err), 0);
    @(negedge clk);
    chk("div_one_cycle", int'(out_valid), 0);

    // sqrt(1000)
    @(posedge clk); #1;
    send(1'b1, 16'd1000, 8'd3);
    wait_out(lat);
    chk("root1000_latency", lat, 8);
    chk("root1000_quo", int'(out_quo), 31);
    chk("root1000_rem", int'(out_rem), 39);
    chk("root1000_err", int'(out_err), 0);

    // sqrt(65535), divisor input ignored
    @(posedge clk); #1;
    send(1'b1, 16'd65535, 8'hA5);
    wait_out(lat);
    chk("root65535_latency", lat, 8);
    chk("root65535_quo", int'(out_quo), 255);
    chk("root65535_rem", int'(out_rem), 510);

    // 500 / 0
    @(posedge clk); #1;
    send(1'b0, 16'd500, 8'd0);
    wait_out(lat);
    chk("dz_latency", lat, 1);
    chk("dz_quo", int'(out_quo), 65535);
    chk("dz_rem", int'(out_rem), 500);
    chk("dz_err", int'(out_err), 1);

    // Backpressure: 65535 / 1 held for 5 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 16'd65535, 8'd1);
    wait_out(lat);
    chk("bp_latency", lat, 16);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_quo", int'(out_quo), 65535);
      chk("bp_rem", int'(out_rem), 0);
      chk("bp_err", int'(out_err), 0);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_until_edge", int'(out_valid), 1);
    @(negedge clk);
    chk("bp_released", int'(out_valid), 0);

    // Reset at T+5 of a division
    @(posedge clk); #1;
    send(1'b0, 16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_idle", int'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      chk("no_stale_valid", int'(out_valid), 0);
    end
    chk("in_ready_after_midreset", int'(in_ready), 1);

    // Random phase 1: in_valid held high, operands change every cycle
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_mode   = 1'($urandom);
      in_data_1 = DW'($urandom);
      in_data_2 = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("phase1_drained", exp_q.size(), 0);

    // Random phase 2: sporadic requests
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_mode   = 1'($urandom);
      in_data_1 = ($urandom_range(0, 15) == 0) ? '1 : DW'($urandom);
      in_data_2 = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("phase2_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_root_core.md
DIV_ROOT_CORE -- requirements
Module: div_root_core

Interface
REQ-001 SHALL have parameter DW, default 16, meaning operand/result width; even, range 4..32.
REQ-002 SHALL have parameter VW, default 8, meaning divisor width; range 1..DW.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_mode, input, 1, 0 = unsigned division, 1 = integer square root.
REQ-008 SHALL have port in_data_1, input, DW, dividend or radicand.
REQ-009 SHALL have port in_data_2, input, VW, divisor; ignored when in_mode = 1.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port out_quo, output, DW, quotient or root (root zero-extended).
REQ-013 SHALL have port out_rem, output, DW, remainder (division: zero-extended; root: x - r*r).
REQ-014 SHALL have port out_err, output, 1, divide-by-zero flag, valid with out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, DIV, ROOT, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request at edge T when in_valid && in_ready; operands and mode are captured at T, later input changes ignored.
REQ-017 SHALL, on acceptance with in_mode = 0 and in_data_2 != 0, enter DIV and perform restoring division, one quotient bit per cycle, MSB first, DW iterations.
REQ-018 SHALL, on acceptance with in_mode = 1, enter ROOT and perform digit-by-digit square root, two radicand bits per cycle, DW/2 iterations.
REQ-019 SHALL latch results and set out_valid at edge T+DW (division) or T+DW/2 (root), entering DONE.
REQ-020 SHALL, on division with in_data_2 = 0, skip iteration: at edge T+1 enter DONE with out_quo = all ones, out_rem = in_data_1, out_err = 1.
REQ-021 SHALL drive out_err = 0 for every non-divide-by-zero result.
REQ-022 SHALL hold out_valid, out_quo, out_rem, out_err stable in DONE until out_ready = 1 is sampled; that edge clears out_valid and returns to IDLE.
REQ-023 SHALL not accept a request in the cycle the result is consumed (in_ready = 0 in DONE); earliest next acceptance is the following edge.
REQ-024 SHALL use a down-counter of ceil(log2(DW+1)) bits for iteration count; no iteration beyond the counted limit.
REQ-025 SHALL satisfy, for division, in_data_1 = out_quo*in_data_2 + out_rem with out_rem < in_data_2.
REQ-026 SHALL satisfy, for root, out_quo*out_quo <= in_data_1 < (out_quo+1)^2, out_rem = in_data_1 - out_quo^2.
REQ-027 SHALL keep out_quo/out_rem/out_err holding the last result outside DONE (values don't-care for checking when out_valid = 0).

Reset
REQ-028 SHALL, while rst_n = 0, force state IDLE, in_ready = 1 after release, out_valid = 0, out_err = 0, out_quo = 0, out_rem = 0, counter = 0.
REQ-029 SHALL, on reset assertion mid-computation or in DONE, abandon the operation immediately; no result is produced after release.

Verification (DW=16, VW=8)
REQ-030 SHALL test division 1000 / 7, out_ready = 1 -> out_valid at T+16, out_quo = 142, out_rem = 6, out_err = 0, one cycle.
REQ-031 SHALL test root 1000 and root 65535 -> out_valid at T+8; (31, 39) and (255, 510).
REQ-032 SHALL test divide-by-zero 500 / 0 -> out_valid at T+1, out_quo = 65535, out_rem = 500, out_err = 1.
REQ-033 SHALL test backpressure: 65535 / 1 with out_ready = 0 for 5 cycles -> out_valid and outputs (65535, 0) stable throughout; in_ready = 0; released on out_ready.
REQ-034 SHALL test in_valid held high back-to-back with operand changes mid-operation -> each result matches the operands captured at its acceptance edge, no lost or duplicated results.
REQ-035 SHALL test rst_n pulsed low at T+5 of a division -> out_valid = 0 asynchronously, in_ready = 1 after release, no stale out_valid.
